dice_button_conditioner: RTL and testbench
==========================================

Name: dice_button_conditioner

Overview:
- Upstream front end for the dice roller; drives its roll-request input.
- Turns a raw, bouncy, asynchronous pad level into a clean debounced level plus press/release pulses, a long-press flag and a press counter.
- Samples the synchronized input only on prescaled ticks, so mechanical bounce shorter than the debounce window is rejected.

Parameters:
- SYNC_STAGES, 2: synchronizer flop count (>=2).
- TICK_W, 10: prescaler width; one tick every 2^TICK_W clocks.
- DB_TICKS, 4: consecutive equal samples needed to accept a press or release (>=2).
- HOLD_TICKS, 64: ticks in the pressed state before long_press asserts (>=2).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous active-high reset
- btn_raw  in  1  raw pad level, asynchronous to wb_clk_i
- invert  in  1  1 = button is active-low; applied after synchronization
- btn_level  out  1  debounced level; feeds the roller's roll input
- press_pulse  out  1  one-cycle pulse on accepted press
- release_pulse  out  1  one-cycle pulse on accepted release
- long_press  out  1  high from long-press detection until accepted release
- press_count  out  8  accepted presses, wraps 255->0

Behaviour:
- Interface: one clock, wb_clk_i; reset wb_rst_i is asynchronous and active-high.
- Reset: all flops clear immediately, including sync chain, prescaler, FSM (IDLE) and counters. All outputs read 0.
- Sampled value: s = sync_out XOR invert. A change of invert is treated as an input change and must be debounced.
- Prescaler: TICK_W-bit counter increments every clock. tick=1 when it is all-ones. The first tick comes 2^TICK_W clocks after reset release.
- FSM: evaluated only on tick cycles; otherwise it holds state. States are IDLE, DB_PRESS, PRESSED, HELD, DB_RELEASE.
  - IDLE: s=1 -> DB_PRESS, db_cnt<=1.
  - DB_PRESS:
    - s=0 -> IDLE.
    - s=1 with db_cnt==DB_TICKS-1 -> PRESSED, hold_cnt<=0, btn_level<=1, press_pulse<=1, press_count++.
    - Otherwise db_cnt++.
  - PRESSED:
    - s=0 -> DB_RELEASE, db_cnt<=1, ret<=PRESSED.
    - s=1 with hold_cnt==HOLD_TICKS-1 -> HELD, long_press<=1.
    - Otherwise hold_cnt++.
  - HELD: s=0 -> DB_RELEASE, db_cnt<=1, ret<=HELD.
  - DB_RELEASE:
    - s=1 -> ret. hold_cnt is frozen; no pulse.
    - s=0 with db_cnt==DB_TICKS-1 -> IDLE; btn_level<=0, long_press<=0, release_pulse<=1.
    - Otherwise db_cnt++.
- Outputs are registered.
  - Pulses are high for exactly the one cycle in which the new state is visible, then cleared.
  - btn_level stays 1 through DB_RELEASE.
- Widths: db_cnt is $clog2(DB_TICKS) bits; hold_cnt is $clog2(HOLD_TICKS) bits; neither ever wraps.
- Boundaries:
  - Glitches between ticks are invisible.
  - A press shorter than DB_TICKS samples yields nothing.
  - press_count wraps silently.
  - Reset mid-press drops outputs without a release_pulse.
  - press_pulse and release_pulse are never high in the same cycle.

Decomposition:
- Shared package dice_pkg holds the state encoding localparams (IDLE..DB_RELEASE) and the default tick width.
- One sub-module, btn_sync: a SYNC_STAGES-deep synchronizer with async reset to 0.
- Prescaler and FSM stay in the top module.

Test Plan:
- Bench parameters: TICK_W=2, DB_TICKS=3, HOLD_TICKS=5.
- Reset: assert wb_rst_i mid-cycle, hold btn_raw=0 for 100 clocks after release -> all outputs 0 throughout.
- Clean press: btn_raw 0->1 held 60 clocks -> press_pulse exactly once, 10-14 clocks after the edge. btn_level rises in that same cycle; press_count=1.
- Bounce reject: btn_raw=1 for 5 clocks then 0 -> no press_pulse; btn_level stays 0; press_count=0.
- Long press and release:
  - Hold btn_raw=1 -> long_press rises exactly 20 clocks after press_pulse.
  - Drop btn_raw -> release_pulse once; btn_level and long_press fall in that same cycle; press_count stays 1.
- Release glitch: while PRESSED, btn_raw=0 for 3 clocks -> no release_pulse, no second press_pulse; long_press is delayed by at most 8 clocks.
- Polarity and reset mid-operation:
  - invert=1 with btn_raw idle at 1 -> no activity. Pulling btn_raw low accepts a press.
  - Assert wb_rst_i in HELD -> outputs 0 before the next clock edge; no release_pulse; press_count=0.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared definitions for the dice roller front end: FSM state encoding and
// the default prescaler width.
package dice_pkg;

  localparam int TICK_W_DEFAULT = 10;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] DB_PRESS   = 3'd1;
  localparam logic [2:0] PRESSED    = 3'd2;
  localparam logic [2:0] HELD       = 3'd3;
  localparam logic [2:0] DB_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE       = IDLE,
    S_DB_PRESS   = DB_PRESS,
    S_PRESSED    = PRESSED,
    S_HELD       = HELD,
    S_DB_RELEASE = DB_RELEASE
  } state_t;

endpackage

// File: rtl/btn_sync.sv
// Multi-flop synchronizer bringing the asynchronous pad level into the
// system clock domain; clears to 0 on reset.
module btn_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // shift the raw level through the synchronizer chain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= {STAGES{1'b0}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/dice_button_conditioner.sv
// Debounces a raw button into a clean level, press/release pulses, a
// long-press flag and a wrapping press counter for the dice roller.
module dice_button_conditioner
  import dice_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TICK_W      = TICK_W_DEFAULT,
  parameter int DB_TICKS    = 4,
  parameter int HOLD_TICKS  = 64
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       btn_raw,
  input  logic       invert,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output logic [7:0] press_count
);

  localparam int DB_W   = $clog2(DB_TICKS);
  localparam int HOLD_W = $clog2(HOLD_TICKS);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  logic w_sync;
  logic w_s;
  logic w_tick;

  logic [TICK_W-1:0] r_presc;
  state_t            r_state;
  state_t            r_ret;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_level;
  logic              r_press;
  logic              r_release;
  logic              r_long;
  logic [7:0]        r_count;

  btn_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk(wb_clk_i),
    .i_rst(wb_rst_i),
    .i_d  (btn_raw),
    .o_q  (w_sync)
  );

  // Polarity is applied after synchronization, so a flip of invert is
  // debounced exactly like a pad edge.
  assign w_s    = w_sync ^ invert;
  assign w_tick = &r_presc;

  // free-running prescaler; all-ones marks a sampling tick
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_presc <= {TICK_W{1'b0}};
    end else begin
      r_presc <= r_presc + TICK_W'(1);
    end
  end

  // debounce / hold FSM with registered outputs, advanced only on ticks
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= S_IDLE;
      r_ret      <= S_IDLE;
      r_db_cnt   <= {DB_W{1'b0}};
      r_hold_cnt <= HOLD_ZERO;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
      r_count    <= 8'd0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_IDLE: begin
            if (w_s) begin
              r_state  <= S_DB_PRESS;
              r_db_cnt <= DB_ONE;
            end
          end
          S_DB_PRESS: begin
            if (!w_s) begin
              r_state <= S_IDLE;
            end else if (r_db_cnt == DB_LAST) begin
              r_state    <= S_PRESSED;
              r_hold_cnt <= HOLD_ZERO;
              r_level    <= 1'b1;
              r_press    <= 1'b1;
              r_count    <= r_count + 8'd1;
            end else begin
              r_db_cnt <= r_db_cnt + DB_ONE;
            end
          end
          S_PRESSED: begin
            if (!w_s) begin
              r_state  <= S_DB_RELEASE;
              r_db_cnt <= DB_ONE;
              r_ret    <= S_PRESSED;
            end else if (r_hold_cnt == HOLD_LAST) begin
              r_state <= S_HELD;
              r_long  <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_ONE;
            end
          end
          S_HELD: begin
            if (!w_s) begin
              r_state  <= S_DB_RELEASE;
              r_db_cnt <= DB_ONE;
              r_ret    <= S_HELD;
            end
          end
          S_DB_RELEASE: begin
            // a bounce back to 1 resumes where we left off; hold_cnt stays frozen
            if (w_s) begin
              r_state <= r_ret;
            end else if (r_db_cnt == DB_LAST) begin
              r_state   <= S_IDLE;
              r_level   <= 1'b0;
              r_long    <= 1'b0;
              r_release <= 1'b1;
            end else begin
              r_db_cnt <= r_db_cnt + DB_ONE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_press    = r_long;
  assign press_count   = r_count;

endmodule

// File: tb/tb_dice_button_conditioner.sv
// Self-checking bench: directed scenarios plus random bounce, every cycle
// compared against a run-length model of the debouncer.
module tb_dice_button_conditioner;

  localparam int SYNC_STAGES = 2;
  localparam int TICK_W      = 2;
  localparam int DB_TICKS    = 3;
  localparam int HOLD_TICKS  = 5;
  localparam int TICK_PERIOD = 1 << TICK_W;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_raw = 1'b0;
  logic       invert = 1'b0;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press;
  logic [7:0] press_count;

  always #5 clk = ~clk;

  dice_button_conditioner #(
    .SYNC_STAGES(SYNC_STAGES),
    .TICK_W     (TICK_W),
    .DB_TICKS   (DB_TICKS),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .btn_raw      (btn_raw),
    .invert       (invert),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .press_count  (press_count)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // model: accepted level, run of consecutive samples disagreeing with it,
  // and number of undisturbed pressed samples toward the long press
  bit         m_level, m_long, m_press, m_release;
  logic [7:0] m_count;
  int         m_run, m_steady, m_edge;
  bit         m_hist[$];

  int cyc_no = 0;
  int n_press_seen, n_release_seen;
  int last_press_cyc = -1000;
  int long_rise_cyc = -1000;
  bit prev_long;
  int start_cyc, lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_long = 0; m_press = 0; m_release = 0;
    m_count = 8'd0; m_run = 0; m_steady = 0; m_edge = 0;
    m_hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(1'b0);
  endtask

  task automatic model_edge(input bit raw, input bit inv);
    bit s;
    s = m_hist.pop_front() ^ inv;
    m_hist.push_back(raw);
    m_edge++;
    m_press = 0;
    m_release = 0;
    if ((m_edge % TICK_PERIOD) == 0) begin
      if (!m_level) begin
        if (s) begin
          m_run++;
          if (m_run == DB_TICKS) begin
            m_level = 1; m_press = 1; m_count = m_count + 8'd1;
            m_run = 0; m_steady = 0;
          end
        end else m_run = 0;
      end else begin
        if (!s) begin
          m_run++;
          if (m_run == DB_TICKS) begin
            m_level = 0; m_long = 0; m_release = 1; m_run = 0;
          end
        end else begin
          if (m_run == 0 && !m_long) begin
            m_steady++;
            if (m_steady == HOLD_TICKS) m_long = 1;
          end
          m_run = 0;
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rst) model_edge(btn_raw, invert);
      #1;
      cyc_no++;
      check("btn_level", btn_level, m_level);
      check("press_pulse", press_pulse, m_press);
      check("release_pulse", release_pulse, m_release);
      check("long_press", long_press, m_long);
      check("press_count", press_count, m_count);
      check("pulse_exclusive", press_pulse & release_pulse, 1'b0);
      if (press_pulse) begin n_press_seen++; last_press_cyc = cyc_no; end
      if (release_pulse) n_release_seen++;
      if (long_press && !prev_long) long_rise_cyc = cyc_no;
      prev_long = long_press;
    end
  endtask

  // assert reset between edges and confirm outputs clear before any edge
  task automatic reset_async();
    #3 rst = 1'b1;
    model_reset();
    prev_long = 0;
    #1;
    check("rst_level", btn_level, 1'b0);
    check("rst_press", press_pulse, 1'b0);
    check("rst_release", release_pulse, 1'b0);
    check("rst_long", long_press, 1'b0);
    check("rst_count", press_count, 8'd0);
    cyc(3);
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #22 rst = 1'b0;

    // idle after reset
    cyc(100);
    check("idle_no_press", n_press_seen, 0);

    // short bounce is rejected
    btn_raw = 1'b1; cyc(5);
    btn_raw = 1'b0; cyc(40);
    check("bounce_no_press", n_press_seen, 0);
    check("bounce_count", press_count, 8'd0);

    // clean press, then long press timing
    n_press_seen = 0;
    btn_raw = 1'b1;
    start_cyc = cyc_no + 1;
    cyc(60);
    check("clean_press_once", n_press_seen, 1);
    lat = last_press_cyc - start_cyc + 1;
    check("clean_press_latency", (lat >= 10 && lat <= 14), 1'b1);
    check("clean_count", press_count, 8'd1);
    check("long_delay", long_rise_cyc - last_press_cyc, 20);

    // release
    n_release_seen = 0;
    btn_raw = 1'b0; cyc(30);
    check("release_once", n_release_seen, 1);
    check("release_count", press_count, 8'd1);
    check("release_long", long_press, 1'b0);

    // release glitch while pressed
    n_press_seen = 0; n_release_seen = 0;
    btn_raw = 1'b1; cyc(20);
    btn_raw = 1'b0; cyc(3);
    btn_raw = 1'b1; cyc(50);
    check("glitch_no_release", n_release_seen, 0);
    check("glitch_one_press", n_press_seen, 1);
    lat = long_rise_cyc - last_press_cyc;
    check("glitch_long_delay", (lat >= 20 && lat <= 28), 1'b1);
    btn_raw = 1'b0; cyc(30);

    // active-low polarity, then reset while held
    n_press_seen = 0; n_release_seen = 0;
    invert = 1'b1; btn_raw = 1'b1; cyc(40);
    check("inv_idle_no_press", n_press_seen, 0);
    btn_raw = 1'b0; cyc(60);
    check("inv_press", n_press_seen, 1);
    check("inv_held", long_press, 1'b1);
    reset_async();
    invert = 1'b0;
    #3 rst = 1'b0;
    cyc(20);
    check("rst_no_release", n_release_seen, 0);

    // random bounce and polarity flips
    for (int k = 0; k < 60; k++) begin
      btn_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) invert = ~invert;
      cyc($urandom_range(1, 40));
    end

    // counter wrap
    invert = 1'b0; btn_raw = 1'b0;
    reset_async();
    #3 rst = 1'b0;
    cyc(20);
    for (int k = 0; k < 256; k++) begin
      btn_raw = 1'b1; cyc(16);
      btn_raw = 1'b0; cyc(16);
    end
    check("wrap_count", press_count, 8'd0);
    btn_raw = 1'b1; cyc(16);
    check("wrap_plus_one", press_count, 8'd1);
    btn_raw = 1'b0; cyc(16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
